// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: valid/ready FIFO controller around a single-port synchronous RAM.
// A 3-entry output buffer hides the 1-cycle RAM read latency. When the RAM is
// empty and no read is in flight, incoming words bypass the RAM entirely.
module spram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 4)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int RC_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [RC_W-1:0]       ram_cnt;
    logic                  rd_inflight;

    logic [DATA_WIDTH-1:0] obuf [3];
    logic [1:0]            obuf_head;
    logic [1:0]            obuf_cnt;
    logic [1:0]            obuf_tail;
    logic [2:0]            tail_sum;

    logic                  rd_issue;
    logic                  bypass_ok;
    logic                  wr_fire;
    logic                  byp_fire;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Port arbitration: reads take the RAM whenever the output side has room,
    // writes only when no read is issued; bypass when the RAM path is idle.
    always_comb begin
        rd_issue  = !rst && (ram_cnt != '0) &&
                    (({1'b0, obuf_cnt} + {2'b0, rd_inflight}) < 3'd3);
        bypass_ok = (ram_cnt == '0) && !rd_inflight && (obuf_cnt != 2'd3);
        s_ready   = !rst && (bypass_ok || ((ram_cnt < RC_W'(FIFO_DEPTH)) && !rd_issue));
        wr_fire   = s_valid && s_ready && !bypass_ok;
        byp_fire  = s_valid && s_ready && bypass_ok;
        push      = rd_inflight || byp_fire;
        push_data = rd_inflight ? ram_dout : s_data;
        m_valid   = (obuf_cnt != 2'd0);
        pop       = m_valid && m_ready;
        m_data    = obuf[obuf_head];
        ram_en    = rd_issue || wr_fire;
        ram_we    = wr_fire;
        ram_addr  = rd_issue ? rd_ptr : wr_ptr;
        ram_din   = s_data;
        tail_sum  = {1'b0, obuf_head} + {1'b0, obuf_cnt};
        obuf_tail = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];
        count     = CNT_WIDTH'(ram_cnt) + CNT_WIDTH'(obuf_cnt) + CNT_WIDTH'(rd_inflight);
    end

    // Control state: RAM pointers/occupancy, in-flight read flag, output buffer indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            obuf_head   <= '0;
            obuf_cnt    <= '0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_issue) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_fire)  wr_ptr <= ptr_inc(wr_ptr);
            // Read and write are mutually exclusive, so at most one of these applies.
            if (wr_fire)       ram_cnt <= ram_cnt + RC_W'(1);
            else if (rd_issue) ram_cnt <= ram_cnt - RC_W'(1);
            if (push && !pop)      obuf_cnt <= obuf_cnt + 2'd1;
            else if (pop && !push) obuf_cnt <= obuf_cnt - 2'd1;
            if (pop) obuf_head <= (obuf_head == 2'd2) ? 2'd0 : obuf_head + 2'd1;
        end
    end

    // Output buffer payload storage; contents are meaningless while obuf_cnt is 0.
    always_ff @(posedge clk) begin
        if (!rst && push) obuf[obuf_tail] <= push_data;
    end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Testbench for spram_fifo_ctrl: directed scenarios plus randomized traffic,
// checked by a queue scoreboard and a monitor sampling on the falling edge.
module tb_spram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 4);
    localparam int CAP   = DEPTH + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [CW-1:0] count;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            wcnt   = 0;
    int            rcnt   = 0;
    int            n_acc  = 0;
    bit            armed  = 1'b0;

    spram_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .count(count)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Monitor: samples mid-cycle, checks occupancy and RAM addressing, scoreboards data.
    always @(negedge clk) begin
        if (armed) begin
            chk("count_vs_model", 32'(count), 32'(exp_q.size()));
            if (count > CW'(CAP)) chk("count_cap", 32'(count), CAP);
            if (exp_q.size() == CAP) chk("s_ready_full", 32'(s_ready), 0);
            if (m_valid && exp_q.size() == 0) chk("m_valid_empty", 32'(m_valid), 0);
            if (rst) begin
                chk("s_ready_rst", 32'(s_ready), 0);
                chk("ram_en_rst", 32'(ram_en), 0);
            end
            if (ram_en && ram_we) begin
                chk("wr_needs_hs", 32'(s_valid && s_ready), 1);
                chk("wr_addr", 32'(ram_addr), 32'(wcnt % DEPTH));
                wcnt++;
            end else if (ram_en) begin
                chk("rd_addr", 32'(ram_addr), 32'(rcnt % DEPTH));
                rcnt++;
            end
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
                else chk("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (!rst && s_valid && s_ready) begin
                exp_q.push_back(s_data);
                n_acc++;
            end
            if (rst) begin
                exp_q.delete();
                wcnt = 0;
                rcnt = 0;
            end
        end
    end

    task automatic push_seq(input int first, input int last, input int cycles);
        int nxt = first;
        bit acc;
        for (int c = 0; c < cycles; c++) begin
            s_valid = (nxt <= last);
            s_data  = DW'(nxt);
            @(negedge clk);
            acc = s_valid && s_ready;
            cyc();
            if (acc) nxt++;
        end
        s_valid = 1'b0;
        chk("push_seq_accepted", 32'(nxt), 32'(first + (last - first + 1 < CAP ? last - first + 1 : CAP)));
    endtask

    initial begin
        bit found;
        // Reset and idle
        @(posedge clk);
        #1 armed = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("s_ready_after_rst", 32'(s_ready), 1);
        chk("m_valid_after_rst", 32'(m_valid), 0);
        chk("count_after_rst", 32'(count), 0);
        chk("ram_en_idle", 32'(ram_en), 0);
        cyc();

        // Bypass: one word straight through
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        cyc();
        s_valid = 1'b0;
        chk("byp_m_valid", 32'(m_valid), 1);
        chk("byp_m_data", 32'(m_data), 32'h A5);
        cyc();
        chk("byp_count", 32'(count), 0);
        chk("byp_no_ram", 32'(wcnt + rcnt), 0);

        // Fill with consumer stalled
        m_ready = 1'b0;
        push_seq(0, 20, 30);
        chk("fill_count", 32'(count), CAP);
        chk("fill_s_ready", 32'(s_ready), 0);
        chk("fill_m_data", 32'(m_data), 0);
        chk("fill_writes", 32'(wcnt), DEPTH);

        // Drain: one word per cycle with no gaps
        m_ready = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            @(negedge clk);
            chk("drain_no_gap", 32'(m_valid), 1);
            cyc();
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_m_valid", 32'(m_valid), 0);

        // Reset while a RAM read is in flight
        m_ready = 1'b0;
        push_seq(100, 104, 8);
        m_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (ram_en && !ram_we) found = 1'b1;
        end
        chk("rd_seen", 32'(found), 1);
        cyc();
        rst = 1'b1;
        m_ready = 1'b0;
        cyc();
        rst = 1'b0;
        chk("rstmid_m_valid", 32'(m_valid), 0);
        chk("rstmid_count", 32'(count), 0);
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("rstmid_no_stale", 32'(m_valid), 0);
        end

        // Randomized traffic
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("rand_words", 32'(n_acc >= 10000), 1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 100 && count != '0; c++) cyc();
        chk("rand_final_count", 32'(count), 0);
        chk("rand_final_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
